// File: rtl/seg_pkg.sv
// Shared constants and helpers for the 7-segment scan controller.
package seg_pkg;

    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned MAX_DIGITS = 16;
    localparam int unsigned MAX_IDX_W  = 4;
    localparam int unsigned MAX_VAL_W  = DIGIT_W * MAX_DIGITS;

    // One-hot anode select for digit idx, inverted for active-low anodes.
    function automatic logic [MAX_DIGITS-1:0] onehot_anode(
        input logic [MAX_IDX_W-1:0] idx,
        input logic                 active_low
    );
        logic [MAX_DIGITS-1:0] oh;
        oh = MAX_DIGITS'(1) << idx;
        return active_low ? ~oh : oh;
    endfunction

    // Positions above the most significant non-zero nibble; digit 0 is never blanked.
    function automatic logic [MAX_DIGITS-1:0] lz_mask(
        input logic [MAX_VAL_W-1:0] v,
        input int unsigned          digits
    );
        logic [MAX_DIGITS-1:0] m;
        logic [DIGIT_W-1:0]    nib;
        logic                  found;
        m     = '0;
        found = 1'b0;
        for (int unsigned i = MAX_DIGITS - 1; i >= 1; i--) begin
            if (i < digits) begin
                nib = DIGIT_W'(v >> (DIGIT_W * i));
                if (nib != '0) found = 1'b1;
                m[MAX_IDX_W'(i)] = ~found;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Value/load/enable inputs and display-drive outputs of the scan controller.
interface seg_scan_ctrl_if #(
    parameter int unsigned DIGITS = 8
);
    import seg_pkg::*;

    logic [DIGIT_W*DIGITS-1:0] value;
    logic                      load;
    logic                      enable;
    logic [DIGIT_W-1:0]        digit;
    logic                      enable_segs;
    logic [DIGITS-1:0]         an;
    logic                      frame_done;

    modport master (
        output value, load, enable,
        input  digit, enable_segs, an, frame_done
    );

    modport slave (
        input  value, load, enable,
        output digit, enable_segs, an, frame_done
    );

endinterface

// File: rtl/seg_prescaler.sv
// Digit-slot prescaler: tick in the cycle the count reaches DIV-1, cleared while en=0.
module seg_prescaler
    import seg_pkg::*;
#(
    parameter int unsigned DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int unsigned          CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0]     CNT_MAX = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    // Wrapping slot counter, synchronously cleared when disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  r_cnt <= '0;
        else if (!en)             r_cnt <= '0;
        else if (r_cnt == CNT_MAX) r_cnt <= '0;
        else                      r_cnt <= r_cnt + CNT_W'(1);
    end

    assign tick = en && (r_cnt == CNT_MAX);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with frame-aligned double-buffered loads.
// Optional: define LEADING_ZERO_BLANK_EN to blank digits above the top non-zero nibble.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned DIGITS           = 8,
    parameter int unsigned CLK_DIV          = 50000,
    parameter bit          ANODE_ACTIVE_LOW = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    seg_scan_ctrl_if.slave  bus
);

    localparam int unsigned        IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned        VAL_W    = DIGIT_W * DIGITS;
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(DIGITS - 1);
    localparam logic [DIGITS-1:0]  AN_OFF   = {DIGITS{ANODE_ACTIVE_LOW}};

    logic               r_run;
    logic [IDX_W-1:0]   r_idx;
    logic [VAL_W-1:0]   r_buf;
    logic [VAL_W-1:0]   r_shadow;
    logic               r_pend;
    logic [DIGIT_W-1:0] r_digit;
    logic               r_enable_segs;
    logic [DIGITS-1:0]  r_an;
    logic               r_frame_done;

    logic               w_pres_en;
    logic               w_tick;
    logic               w_boundary;
    logic               w_commit;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic [VAL_W-1:0]   w_shadow_nxt;
    logic [DIGITS-1:0]  w_blank_nxt;
    logic [DIGIT_W-1:0] w_digit_nxt;
    logic [DIGITS-1:0]  w_an_nxt;
    logic               w_blank_bit;

    // Prescaler is held for the first enabled cycle so digit 0 gets a full slot after re-enable.
    assign w_pres_en = bus.enable & r_run;

    seg_prescaler #(.DIV(CLK_DIV)) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (w_pres_en),
        .tick (w_tick)
    );

    // Next scan index, frame boundary and the values the output registers will show.
    always_comb begin
        w_boundary   = w_tick && (r_idx == LAST_IDX);
        w_commit     = w_boundary && r_pend;
        w_idx_nxt    = r_idx;
        if (!bus.enable)
            w_idx_nxt = '0;
        else if (w_tick)
            w_idx_nxt = (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);
        w_shadow_nxt = w_commit ? r_buf : r_shadow;
        w_digit_nxt  = DIGIT_W'(w_shadow_nxt >> (DIGIT_W * w_idx_nxt));
        w_an_nxt     = DIGITS'(onehot_anode(MAX_IDX_W'(w_idx_nxt), ANODE_ACTIVE_LOW));
        w_blank_bit  = 1'(w_blank_nxt >> w_idx_nxt);
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] r_blank;

    assign w_blank_nxt = w_commit ? DIGITS'(lz_mask(MAX_VAL_W'(r_buf), DIGITS)) : r_blank;

    // Blank mask follows the shadow value, recomputed only at commits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_blank <= DIGITS'(lz_mask('0, DIGITS));
        else     r_blank <= w_blank_nxt;
    end
`else
    assign w_blank_nxt = '0;
`endif

    // Scan index, run flag, pending buffer and shadow; a load always wins over the commit clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run    <= 1'b0;
            r_idx    <= '0;
            r_buf    <= '0;
            r_shadow <= '0;
            r_pend   <= 1'b0;
        end else begin
            r_run    <= bus.enable;
            r_idx    <= w_idx_nxt;
            r_shadow <= w_shadow_nxt;
            if (bus.load) begin
                r_buf  <= bus.value;
                r_pend <= 1'b1;
            end else if (w_commit) begin
                r_pend <= 1'b0;
            end
        end
    end

    // Registered display drive; dark whenever scanning is disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_digit       <= '0;
            r_enable_segs <= 1'b0;
            r_an          <= AN_OFF;
            r_frame_done  <= 1'b0;
        end else if (!bus.enable) begin
            r_digit       <= '0;
            r_enable_segs <= 1'b0;
            r_an          <= AN_OFF;
            r_frame_done  <= 1'b0;
        end else begin
            r_digit       <= w_digit_nxt;
            r_enable_segs <= ~w_blank_bit;
            r_an          <= w_an_nxt;
            r_frame_done  <= w_boundary;
        end
    end

    assign bus.digit       = r_digit;
    assign bus.enable_segs = r_enable_segs;
    assign bus.an          = r_an;
    assign bus.frame_done  = r_frame_done;

endmodule
